// File: rtl/nand_truth_checker_if.sv
// nand_truth_checker_if
// Groups the run handshake, result and gate-facing signals of the NAND
// self-test stage.
//   master : requester/test-harness side (drives start, supplies gateY)
//   slave  : checker side (drives busy/done/results and the gate inputs)
//   start          run request
//   busy, done     run in progress / one-cycle end-of-run pulse
//   allPass        run result, 1 when no mismatch was seen
//   errCount       saturating mismatch count (ERR_W bits)
//   firstFail      {A,B} of the first mismatching vector
//   firstFailValid firstFail holds a captured vector
//   drvA, drvB     gate inputs
//   gateY          gate output
interface nand_truth_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             busy;
    logic             done;
    logic             allPass;
    logic             drvA;
    logic             drvB;
    logic             gateY;
    logic [ERR_W-1:0] errCount;
    logic [1:0]       firstFail;
    logic             firstFailValid;

    modport master (
        output start, gateY,
        input  busy, done, allPass, drvA, drvB, errCount, firstFail, firstFailValid
    );

    modport slave (
        input  start, gateY,
        output busy, done, allPass, drvA, drvB, errCount, firstFail, firstFailValid
    );
endinterface

// File: rtl/nand_truth_checker.sv
// nand_truth_checker
// Walks a 2-input NAND gate through all four input vectors, PASSES times,
// holding each vector SETTLE_CYCLES cycles before sampling the gate output
// and scoring it against the expected NAND value.
// Ports:
//   clk   single clock, rising edge
//   rstN  asynchronous active-low reset
//   bus   nand_truth_checker_if slave modport (handshake, results, gate pins)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | gate inputs low, waiting for start; results from last run held
// DRIVE  | current vector on drvA/drvB, settle counter running down
// SAMPLE | vector still held, gateY scored for one cycle
// DONE   | one-cycle done pulse, allPass already valid
module nand_truth_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rstN,
    nand_truth_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SWP_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       vec;
    logic [SWP_W-1:0] sweep;
    logic [CNT_W-1:0] cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       first_fail;
    logic             first_fail_valid;
    logic             all_pass;

    logic             expected;
    logic             mismatch;
    logic             last_vec;
    logic [ERR_W-1:0] err_inc;

    assign expected = ~(vec[1] & vec[0]);
    assign mismatch = (state == SAMPLE) && (bus.gateY != expected);
    assign last_vec = (vec == 2'd3) && (sweep == SWP_LAST);
    assign err_inc  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DRIVE;
            DRIVE:   if (cnt == '0) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.drvA = 1'b0;
        bus.drvB = 1'b0;
        case (state)
            DRIVE, SAMPLE: begin
                bus.busy = 1'b1;
                bus.drvA = vec[1];
                bus.drvB = vec[0];
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vec              <= '0;
            sweep            <= '0;
            cnt              <= '0;
            err_cnt          <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            all_pass         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    vec              <= '0;
                    sweep            <= '0;
                    cnt              <= CNT_LOAD;
                    err_cnt          <= '0;
                    first_fail       <= '0;
                    first_fail_valid <= 1'b0;
                    all_pass         <= 1'b0;
                end
                DRIVE: if (cnt != '0) cnt <= cnt - 1'b1;
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_inc;
                        if (!first_fail_valid) begin
                            first_fail       <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        // fold in this cycle's mismatch so allPass is valid during DONE
                        all_pass <= (err_cnt == '0) && !mismatch;
                    end else begin
                        vec <= vec + 1'b1;
                        if (vec == 2'd3) sweep <= sweep + 1'b1;
                        cnt <= CNT_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.errCount       = err_cnt;
    assign bus.firstFail      = first_fail;
    assign bus.firstFailValid = first_fail_valid;
    assign bus.allPass        = all_pass;
endmodule

// File: tb/tb_nand_truth_checker.sv
module tb_nand_truth_checker;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    // 0: SETTLE=1 PASSES=1 ERR_W=4; 1: SETTLE=1 PASSES=2 ERR_W=3; 2: SETTLE=2 PASSES=1 ERR_W=4
    nand_truth_checker_if #(.ERR_W(4)) if0 ();
    nand_truth_checker_if #(.ERR_W(3)) if1 ();
    nand_truth_checker_if #(.ERR_W(4)) if2 ();

    nand_truth_checker #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(4)) u0 (.clk(clk), .rstN(rstN), .bus(if0));
    nand_truth_checker #(.SETTLE_CYCLES(1), .PASSES(2), .ERR_W(3)) u1 (.clk(clk), .rstN(rstN), .bus(if1));
    nand_truth_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(4)) u2 (.clk(clk), .rstN(rstN), .bus(if2));

    logic       start_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       pass_v  [3];
    logic       ffv_v   [3];
    logic [1:0] ff_v    [3];
    logic [3:0] err_v   [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic       y_v     [3];
    logic       d1      [3];
    logic       d2      [3];
    int         mode_v  [3];   // 0 NAND, 1 stuck-at-1, 2 AND, 3 NAND with 2-cycle latency

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.gateY = y_v[0];
    assign if1.gateY = y_v[1];
    assign if2.gateY = y_v[2];
    assign busy_v[0] = if0.busy;  assign busy_v[1] = if1.busy;  assign busy_v[2] = if2.busy;
    assign done_v[0] = if0.done;  assign done_v[1] = if1.done;  assign done_v[2] = if2.done;
    assign pass_v[0] = if0.allPass; assign pass_v[1] = if1.allPass; assign pass_v[2] = if2.allPass;
    assign ffv_v[0] = if0.firstFailValid; assign ffv_v[1] = if1.firstFailValid; assign ffv_v[2] = if2.firstFailValid;
    assign ff_v[0] = if0.firstFail; assign ff_v[1] = if1.firstFail; assign ff_v[2] = if2.firstFail;
    assign err_v[0] = if0.errCount; assign err_v[1] = {1'b0, if1.errCount}; assign err_v[2] = if2.errCount;
    assign a_v[0] = if0.drvA; assign a_v[1] = if1.drvA; assign a_v[2] = if2.drvA;
    assign b_v[0] = if0.drvB; assign b_v[1] = if1.drvB; assign b_v[2] = if2.drvB;

    initial begin
        for (int i = 0; i < 3; i++) begin
            d1[i] = 1'b1;
            d2[i] = 1'b1;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            d1[i] <= ~(a_v[i] & b_v[i]);
            d2[i] <= d1[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            y_v[i] = 1'b0;
            case (mode_v[i])
                0:       y_v[i] = ~(a_v[i] & b_v[i]);
                1:       y_v[i] = 1'b1;
                2:       y_v[i] = a_v[i] & b_v[i];
                default: y_v[i] = d2[i];
            endcase
        end
    end

    int total = 0;
    int bad = 0;
    logic [1:0] trace [16];
    logic done_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input int w);
        chk({tag, "_busy"}, 32'(busy_v[w]), 0);
        chk({tag, "_done"}, 32'(done_v[w]), 0);
        chk({tag, "_drv"}, 32'({a_v[w], b_v[w]}), 0);
        chk({tag, "_err"}, 32'(err_v[w]), 0);
        chk({tag, "_ffv"}, 32'(ffv_v[w]), 0);
        chk({tag, "_ff"}, 32'(ff_v[w]), 0);
        chk({tag, "_pass"}, 32'(pass_v[w]), 0);
    endtask

    // Pulses start, counts busy cycles (optionally re-pulsing start at busy
    // cycle pulse_at) and returns at the first non-busy negedge.
    task automatic run(input int w, input int pulse_at, output int nbusy, output logic saw_done);
        @(negedge clk); start_v[w] = 1'b1;
        @(negedge clk); start_v[w] = 1'b0;
        nbusy = 0;
        while (busy_v[w] === 1'b1 && nbusy < 100) begin
            if (nbusy < 16) trace[nbusy] = {a_v[w], b_v[w]};
            nbusy++;
            start_v[w] = (nbusy == pulse_at);
            @(negedge clk);
        end
        start_v[w] = 1'b0;
        saw_done  = done_v[w];
        done_pass = pass_v[w];
    endtask

    task automatic wait_done(input int w, output logic ok);
        int n;
        n = 0;
        while (done_v[w] !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        ok = (done_v[w] === 1'b1);
    endtask

    int nb;
    logic sd;
    logic ok;

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 0;
        end
        #2;
        chk_zero("reset", 0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk_zero("post_reset", 0);

        // good gate
        run(0, -1, nb, sd);
        chk("good_busy", 32'(nb), 8);
        chk("good_done", 32'(sd), 1);
        chk("good_pass_at_done", 32'(done_pass), 1);
        chk("good_err", 32'(err_v[0]), 0);
        chk("good_ffv", 32'(ffv_v[0]), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("good_vec%0d", i), 32'(trace[i]), 32'(i / 2));
        @(negedge clk);
        chk("good_done_one_cycle", 32'(done_v[0]), 0);
        chk("good_pass_hold", 32'(pass_v[0]), 1);

        // stuck-at-1 output
        mode_v[0] = 1;
        run(0, -1, nb, sd);
        chk("stuck_busy", 32'(nb), 8);
        chk("stuck_done", 32'(sd), 1);
        chk("stuck_pass_at_done", 32'(done_pass), 0);
        chk("stuck_err", 32'(err_v[0]), 1);
        chk("stuck_ff", 32'(ff_v[0]), 3);
        chk("stuck_ffv", 32'(ffv_v[0]), 1);

        // inverted gate, two passes, 3-bit counter saturates at 7
        mode_v[1] = 2;
        run(1, -1, nb, sd);
        chk("sat_busy", 32'(nb), 16);
        chk("sat_done", 32'(sd), 1);
        chk("sat_err", 32'(err_v[1]), 7);
        chk("sat_ff", 32'(ff_v[1]), 0);
        chk("sat_ffv", 32'(ffv_v[1]), 1);
        chk("sat_pass", 32'(pass_v[1]), 0);

        // start pulsed mid-run is ignored
        mode_v[0] = 0;
        run(0, 3, nb, sd);
        chk("midstart_busy", 32'(nb), 8);
        chk("midstart_done", 32'(sd), 1);
        @(negedge clk);
        chk("midstart_no_restart", 32'(busy_v[0]), 0);

        // start held high: back-to-back runs, results cleared at acceptance
        mode_v[0] = 1;
        @(negedge clk); start_v[0] = 1'b1;
        wait_done(0, ok);
        chk("held_first_done", 32'(ok), 1);
        chk("held_first_err", 32'(err_v[0]), 1);
        @(negedge clk);
        chk("held_idle_gap_busy", 32'(busy_v[0]), 0);
        chk("held_idle_gap_err", 32'(err_v[0]), 1);
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("held_second_busy", 32'(busy_v[0]), 1);
        chk("held_cleared_err", 32'(err_v[0]), 0);
        chk("held_cleared_ffv", 32'(ffv_v[0]), 0);
        wait_done(0, ok);
        chk("held_second_done", 32'(ok), 1);
        chk("held_second_err", 32'(err_v[0]), 1);
        @(negedge clk);

        // reset while vector 2 is driven; AND gate gives two errors first
        mode_v[0] = 2;
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        nb = 0;
        while (!(a_v[0] === 1'b1 && b_v[0] === 1'b0) && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        chk("rst_reached_vec2", 32'({a_v[0], b_v[0]}), 2);
        @(posedge clk); #1;
        chk("rst_pre_err", 32'(err_v[0]), 2);
        rstN = 1'b0;
        #1;
        chk_zero("rst_mid", 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_idle%0d_busy", i), 32'(busy_v[0]), 0);
            chk($sformatf("rst_idle%0d_done", i), 32'(done_v[0]), 0);
        end
        mode_v[0] = 0;
        run(0, -1, nb, sd);
        chk("rst_after_busy", 32'(nb), 8);
        chk("rst_after_pass", 32'(done_pass), 1);

        // 2-cycle latency gate: SETTLE=2 passes, SETTLE=1 fails on vector 11
        mode_v[2] = 3;
        run(2, -1, nb, sd);
        chk("settle2_busy", 32'(nb), 12);
        chk("settle2_pass", 32'(done_pass), 1);
        chk("settle2_err", 32'(err_v[2]), 0);
        mode_v[0] = 3;
        run(0, -1, nb, sd);
        chk("settle1_pass", 32'(done_pass), 0);
        chk("settle1_err", 32'(err_v[0]), 1);
        chk("settle1_ff", 32'(ff_v[0]), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
